pipe_stall_ctrl: RTL
====================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: luStall  input  1  load-use hazard request (freeze PC and IF/ID).
REQ-004 SHALL provide: luFlush  input  1  load-use bubble request (clear ID/EX).
REQ-005 SHALL provide: brTaken  input  1  branch/jump redirect resolved in EX.
REQ-006 SHALL provide: memReq  input  1  MEM stage holds a load or store.
REQ-007 SHALL provide: memRdy  input  1  data memory ack for the current memReq.
REQ-008 SHALL provide: pcEn, fEn, dEn, eEn, mEn  output  1 each  write enables for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-009 SHALL provide: fFlush, dFlush, mFlush  output  1 each  load NOP into IF/ID, ID/EX, MEM/WB.
REQ-010 SHALL provide: memBusy  output  1  FSM in WAIT state.
REQ-011 SHALL provide: memErr  output  1  sticky memory-timeout flag.
REQ-012 SHALL provide: stallCnt  output  16  count of cycles with pcEn=0.

Function
REQ-013 SHALL implement FSM states RUN and WAIT; RUN->WAIT when memReq=1 and memRdy=0; WAIT->RUN when memRdy=1; otherwise hold.
REQ-014 SHALL treat "memory stall" as (RUN and memReq and !memRdy) or (WAIT and !memRdy).
REQ-015 SHALL resolve requests combinationally with priority memory stall > brTaken > load-use (luStall or luFlush) > normal.
REQ-016 Memory stall SHALL drive all five enables 0, mFlush=1, fFlush=0, dFlush=0.
REQ-017 brTaken (no memory stall) SHALL drive all enables 1, fFlush=1, dFlush=1, mFlush=0; a coincident load-use request SHALL be ignored.
REQ-018 Load-use (no memory stall, no brTaken) SHALL drive pcEn=0, fEn=0, dEn=1, eEn=1, mEn=1, dFlush=1, fFlush=0, mFlush=0.
REQ-019 Normal SHALL drive all enables 1, all flushes 0.
REQ-020 WAIT exit cycle (memRdy=1) SHALL be a normal/branch/load-use cycle per REQ-015, i.e. zero added latency after ack.
REQ-021 memRdy=1 in the same cycle as memReq SHALL cause no stall and no state change.
REQ-022 SHALL keep an 8-bit wait counter: cleared on entering WAIT, incremented each WAIT cycle; reaching 255 SHALL set memErr and force WAIT->RUN next edge.
REQ-023 memErr SHALL stay 1 until reset.
REQ-024 stallCnt SHALL increment by 1 on each rising edge where pcEn=0 and rst=0, saturating at 16'hFFFF.
REQ-025 memBusy SHALL equal 1 exactly when state=WAIT.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force state=RUN, wait counter=0, memErr=0, stallCnt=0.
REQ-027 While rst=1, all enables SHALL be 0 and fFlush=dFlush=mFlush=1, regardless of other inputs.
REQ-028 Reset asserted during WAIT SHALL abandon the wait; first cycle after release SHALL be RUN.
REQ-029 After rst deasserts, outputs SHALL follow REQ-015 from the first rising edge.

Verification
REQ-030 Load-use: luStall=1, luFlush=1 for 1 cycle -> pcEn=0, fEn=0, dFlush=1, others enabled; stallCnt 0->1.
REQ-031 Branch vs load-use: brTaken=1, luStall=1 same cycle -> all enables 1, fFlush=dFlush=1; stallCnt unchanged.
REQ-032 Memory wait: memReq=1, memRdy=0 for 3 cycles then memRdy=1 -> memBusy=1 for cycles 2-3, all enables 0 and mFlush=1 for 3 cycles, normal on the 4th; stallCnt=3.
REQ-033 Timeout: memReq=1, memRdy=0 held 300 cycles -> memErr=1 after wait counter hits 255, FSM back to RUN; memErr stays 1 until rst.
REQ-034 Reset mid-wait: enter WAIT, assert rst between edges -> memBusy, memErr, stallCnt drop to 0 without clock edge; enables 0, flushes 1 while rst=1.
REQ-035 Saturation: force 70000 stall cycles -> stallCnt holds 16'hFFFF, no wrap to 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - hazard request / pipeline control bundle for pipe_stall_ctrl
interface pipe_stall_ctrl_if;
    // Hazard and memory requests from the pipeline
    logic        luStall;
    logic        luFlush;
    logic        brTaken;
    logic        memReq;
    logic        memRdy;

    // Per-stage write enables and flushes back to the pipeline
    logic        pcEn;
    logic        fEn;
    logic        dEn;
    logic        eEn;
    logic        mEn;
    logic        fFlush;
    logic        dFlush;
    logic        mFlush;

    // Status
    logic        memBusy;
    logic        memErr;
    logic [15:0] stallCnt;

    // Pipeline side: raises requests, consumes controls
    modport master (
        output luStall, luFlush, brTaken, memReq, memRdy,
        input  pcEn, fEn, dEn, eEn, mEn, fFlush, dFlush, mFlush,
        input  memBusy, memErr, stallCnt
    );

    // Controller side
    modport slave (
        input  luStall, luFlush, brTaken, memReq, memRdy,
        output pcEn, fEn, dEn, eEn, mEn, fFlush, dFlush, mFlush,
        output memBusy, memErr, stallCnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush arbiter with memory-wait FSM and stall counter
module pipe_stall_ctrl (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  waitCnt;
    logic        memErrQ;
    logic [15:0] stallCntQ;

    logic        memStall;
    logic        loadUse;

    logic        pcEnC;
    logic        fEnC;
    logic        dEnC;
    logic        eEnC;
    logic        mEnC;
    logic        fFlushC;
    logic        dFlushC;
    logic        mFlushC;

    // A memory stall is an outstanding access without an ack, whether it is
    // just being issued (RUN) or already being waited on (WAIT). An ack in the
    // same cycle never stalls, so exit from WAIT costs no extra cycle.
    always_comb begin
        memStall = 1'b0;
        if (state == RUN) begin
            memStall = bus.memReq && !bus.memRdy;
        end else begin
            memStall = !bus.memRdy;
        end
    end

    assign loadUse = bus.luStall || bus.luFlush;

    // Priority decode: reset > memory stall > branch redirect > load-use > normal
    always_comb begin
        pcEnC   = 1'b1;
        fEnC    = 1'b1;
        dEnC    = 1'b1;
        eEnC    = 1'b1;
        mEnC    = 1'b1;
        fFlushC = 1'b0;
        dFlushC = 1'b0;
        mFlushC = 1'b0;
        if (rst) begin
            // Hold every stage and fill it with NOPs while in reset
            pcEnC   = 1'b0;
            fEnC    = 1'b0;
            dEnC    = 1'b0;
            eEnC    = 1'b0;
            mEnC    = 1'b0;
            fFlushC = 1'b1;
            dFlushC = 1'b1;
            mFlushC = 1'b1;
        end else if (memStall) begin
            // Freeze the whole pipe; WB must not retire the stalled access twice
            pcEnC   = 1'b0;
            fEnC    = 1'b0;
            dEnC    = 1'b0;
            eEnC    = 1'b0;
            mEnC    = 1'b0;
            mFlushC = 1'b1;
        end else if (bus.brTaken) begin
            // Redirect: squash the two wrong-path instructions behind EX.
            // A load-use hazard on a wrong-path instruction is moot.
            fFlushC = 1'b1;
            dFlushC = 1'b1;
        end else if (loadUse) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX
            pcEnC   = 1'b0;
            fEnC    = 1'b0;
            dFlushC = 1'b1;
        end
    end

    // Memory-wait FSM with timeout watchdog and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            waitCnt <= 8'd0;
            memErrQ <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.memReq && !bus.memRdy) begin
                        state   <= WAIT;
                        waitCnt <= 8'd0;
                    end
                end
                WAIT: begin
                    if (bus.memRdy) begin
                        state <= RUN;
                    end else if (waitCnt == 8'hFF) begin
                        // Memory never answered: give up and flag it
                        state   <= RUN;
                        memErrQ <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCntQ <= 16'd0;
        end else if (!pcEnC && (stallCntQ != 16'hFFFF)) begin
            stallCntQ <= stallCntQ + 16'd1;
        end
    end

    assign bus.pcEn     = pcEnC;
    assign bus.fEn      = fEnC;
    assign bus.dEn      = dEnC;
    assign bus.eEn      = eEnC;
    assign bus.mEn      = mEnC;
    assign bus.fFlush   = fFlushC;
    assign bus.dFlush   = dFlushC;
    assign bus.mFlush   = mFlushC;
    assign bus.memBusy  = (state == WAIT);
    assign bus.memErr   = memErrQ;
    assign bus.stallCnt = stallCntQ;

endmodule
